// File: rtl/cpu_power_sequencer_pkg.sv
// cpu_power_sequencer_pkg: state encodings and per-state output decode for the CPU power sequencer
package cpu_power_sequencer_pkg;
  typedef enum logic [3:0] {
    CPU_OFF      = 4'd0,
    CPU_PWRON    = 4'd1,
    CPU_SETTLE   = 4'd2,
    CPU_RSTHOLD  = 4'd3,
    CPU_BOOTWAIT = 4'd4,
    CPU_HUBDLY   = 4'd5,
    CPU_RUN      = 4'd6,
    CPU_COOL     = 4'd7,
    CPU_FAULT    = 4'd8
  } cpu_state_e;
  typedef struct packed {
    logic pwron;
    logic pmic_rst_inv;
    logic rst_inv;
    logic wrst_inv;
    logic hub_rst_inv;
    logic bootmode;
    logic bank;
    logic fault;
  } cpu_out_t;
  function automatic cpu_out_t decode(input cpu_state_e s);
    cpu_out_t o;
    o.pwron        = s == CPU_PWRON;
    o.pmic_rst_inv = s inside {CPU_PWRON, CPU_SETTLE, CPU_RSTHOLD, CPU_BOOTWAIT, CPU_HUBDLY, CPU_RUN};
    o.rst_inv      = s inside {CPU_BOOTWAIT, CPU_HUBDLY, CPU_RUN};
    o.wrst_inv     = o.rst_inv;
    o.hub_rst_inv  = s == CPU_RUN;
    o.bootmode     = s inside {CPU_RSTHOLD, CPU_BOOTWAIT};
    o.bank         = s inside {CPU_HUBDLY, CPU_RUN};
    o.fault        = s == CPU_FAULT;
    return o;
  endfunction
endpackage

// File: rtl/cpu_power_sequencer_seq_timer.sv
// seq_timer: loadable down-counter that saturates at zero; done while the count is zero
module seq_timer #(
  parameter int TW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done
);
  logic [TW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/cpu_power_sequencer.sv
// cpu_power_sequencer: PMIC power-on, settle, reset release, boot supervision with retry, USB hub release
module cpu_power_sequencer
  import cpu_power_sequencer_pkg::*;
#(
  parameter int TW           = 24,
  parameter int PWRON_CYC    = 64,
  parameter int SETTLE_CYC   = 1048576,
  parameter int RST_HOLD_CYC = 4096,
  parameter int BOOT_TO_CYC  = 8388608,
  parameter int HUB_DLY_CYC  = 4194304,
  parameter int OFF_CYC      = 262144,
  parameter int RETRY_MAX    = 3
) (
  input  logic       sysclk,
  input  logic       reset_INV,
  input  logic       enable,
  input  logic       cpu_resetout,
  output logic       cpu_pmic_pwron,
  output logic       cpu_pmic_reset_INV,
  output logic       cpu_reset_INV,
  output logic       cpu_wreset_INV,
  output logic       usbhub_reset_INV,
  output logic       bootmode_en,
  output logic       cpu_bank_en,
  output logic       fault,
  output logic [3:0] state
);
  cpu_state_e    cur, nxt;
  cpu_out_t      o;
  logic          rs1, rs2, done, load;
  logic [1:0]    retry, retry_nxt;
  logic [TW-1:0] load_val;
  seq_timer #(.TW(TW)) u_timer (
    .clk      (sysclk),
    .rst_n    (reset_INV),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );
  // a synchronised resetout change outranks a coincident timer expiry
  always_comb begin
    nxt = cur;
    retry_nxt = retry;
    if (!enable) begin
      nxt = CPU_OFF;
      retry_nxt = '0;
    end else
      case (cur)
        CPU_OFF:     nxt = CPU_PWRON;
        CPU_PWRON:   nxt = done ? CPU_SETTLE : cur;
        CPU_SETTLE:  nxt = done ? CPU_RSTHOLD : cur;
        CPU_RSTHOLD: nxt = done ? CPU_BOOTWAIT : cur;
        CPU_BOOTWAIT:
          if (rs2) nxt = CPU_HUBDLY;
          else if (done) begin
            retry_nxt = retry + 2'd1;
            nxt = retry_nxt == 2'(RETRY_MAX) ? CPU_FAULT : CPU_COOL;
          end
        CPU_HUBDLY:  nxt = !rs2 ? CPU_BOOTWAIT : done ? CPU_RUN : cur;
        CPU_RUN: begin
          retry_nxt = '0;
          nxt = rs2 ? cur : CPU_BOOTWAIT;
        end
        CPU_COOL:    nxt = done ? CPU_PWRON : cur;
        CPU_FAULT:   nxt = cur;
        default:     nxt = CPU_OFF;
      endcase
  end
  always_comb begin
    load = nxt != cur;
    case (nxt)
      CPU_PWRON:    load_val = TW'(PWRON_CYC - 1);
      CPU_SETTLE:   load_val = TW'(SETTLE_CYC - 1);
      CPU_RSTHOLD:  load_val = TW'(RST_HOLD_CYC - 1);
      CPU_BOOTWAIT: load_val = TW'(BOOT_TO_CYC - 1);
      CPU_HUBDLY:   load_val = TW'(HUB_DLY_CYC - 1);
      CPU_COOL:     load_val = TW'(OFF_CYC - 1);
      default:      load_val = '0;
    endcase
  end
  always_ff @(posedge sysclk or negedge reset_INV)
    if (!reset_INV) begin
      rs1   <= 1'b0;
      rs2   <= 1'b0;
      cur   <= CPU_OFF;
      retry <= '0;
      o     <= '0;
    end else begin
      rs1   <= cpu_resetout;
      rs2   <= rs1;
      cur   <= nxt;
      retry <= retry_nxt;
      o     <= decode(nxt);
    end
  assign state              = cur;
  assign cpu_pmic_pwron     = o.pwron;
  assign cpu_pmic_reset_INV = o.pmic_rst_inv;
  assign cpu_reset_INV      = o.rst_inv;
  assign cpu_wreset_INV     = o.wrst_inv;
  assign usbhub_reset_INV   = o.hub_rst_inv;
  assign bootmode_en        = o.bootmode;
  assign cpu_bank_en        = o.bank;
  assign fault              = o.fault;
endmodule

// File: tb/tb_cpu_power_sequencer.sv
// tb_cpu_power_sequencer: timestamped state-transition scoreboard against an elapsed-time reference model
module tb_cpu_power_sequencer;
  localparam int TW = 8;
  // state durations in cycles and output vectors {pwron,pmic,rst,wrst,hub,boot,bank,fault}
  localparam int         DUR  [0:8] = '{0, 4, 8, 4, 16, 8, 0, 4, 0};
  localparam logic [7:0] OUTS [0:8] = '{8'h00, 8'hC0, 8'h40, 8'h44, 8'h74, 8'h72, 8'h7A, 8'h00, 8'h01};
  typedef struct {
    int         t;
    int         st;
    logic [7:0] o;
  } exp_t;
  logic sysclk = 1'b0, reset_INV = 1'b0, enable = 1'b0, cpu_resetout = 1'b0;
  logic cpu_pmic_pwron, cpu_pmic_reset_INV, cpu_reset_INV, cpu_wreset_INV;
  logic usbhub_reset_INV, bootmode_en, cpu_bank_en, fault;
  logic [3:0] state;
  logic [7:0] outv;
  exp_t q[$];
  bit   in_at[int];
  int   compared = 0, mismatched = 0, cyc = 0;
  int   m_st = 0, m_before = 0, m_entry = 0, m_retry = 0;
  cpu_power_sequencer #(
    .TW(TW), .PWRON_CYC(4), .SETTLE_CYC(8), .RST_HOLD_CYC(4),
    .BOOT_TO_CYC(16), .HUB_DLY_CYC(8), .OFF_CYC(4), .RETRY_MAX(3)
  ) dut (
    .sysclk(sysclk), .reset_INV(reset_INV), .enable(enable), .cpu_resetout(cpu_resetout),
    .cpu_pmic_pwron(cpu_pmic_pwron), .cpu_pmic_reset_INV(cpu_pmic_reset_INV),
    .cpu_reset_INV(cpu_reset_INV), .cpu_wreset_INV(cpu_wreset_INV),
    .usbhub_reset_INV(usbhub_reset_INV), .bootmode_en(bootmode_en),
    .cpu_bank_en(cpu_bank_en), .fault(fault), .state(state)
  );
  assign outv = {cpu_pmic_pwron, cpu_pmic_reset_INV, cpu_reset_INV, cpu_wreset_INV,
                 usbhub_reset_INV, bootmode_en, cpu_bank_en, fault};
  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask
  task automatic push(input int t, input int st);
    exp_t e;
    e.t = t;
    e.st = st;
    e.o = OUTS[st];
    q.push_back(e);
  endtask
  // predicts the clock edge that follows the inputs just driven
  task automatic predict();
    int k, nx;
    bit s, done;
    k = cyc + 1;
    m_before = m_st;
    if (!reset_INV) begin
      in_at[k] = 1'b0;
      return;
    end
    in_at[k] = cpu_resetout;
    s = in_at.exists(k - 2) ? in_at[k - 2] : 1'b0;
    done = (k - m_entry) == DUR[m_st];
    nx = m_st;
    if (!enable) begin
      nx = 0;
      m_retry = 0;
    end else if (m_st == 0) nx = 1;
    else if (m_st >= 1 && m_st <= 3 && done) nx = m_st + 1;
    else if (m_st == 7 && done) nx = 1;
    else if (m_st == 4) begin
      if (s) nx = 5;
      else if (done) begin
        m_retry++;
        nx = m_retry == 3 ? 8 : 7;
      end
    end else if (m_st == 5) nx = !s ? 4 : done ? 6 : 5;
    else if (m_st == 6) nx = s ? 6 : 4;
    if (nx == 6) m_retry = 0;
    if (nx != m_st) begin
      push(k, nx);
      m_st = nx;
      m_entry = k;
    end
  endtask
  task automatic step(input bit en, input bit ro);
    @(posedge sysclk);
    #1;
    enable = en;
    cpu_resetout = ro;
    predict();
  endtask
  task automatic wait_st(input int s, input int budget, input bit en, input bit ro);
    int n = 0;
    while (m_st != s && n < budget) begin
      step(en, ro);
      n++;
    end
    if (m_st != s) begin
      compared++;
      mismatched++;
      $display("FAIL wait_state: model state %0d, required %0d within %0d cycles", m_st, s, budget);
    end
  endtask
  task automatic hard_reset();
    @(negedge sysclk);
    #1;
    reset_INV = 1'b0;
    enable = 1'b0;
    cpu_resetout = 1'b0;
    if (q.size() > 0 && q[$].t == cyc + 1) void'(q.pop_back());
    if (m_before != 0) begin
      push(cyc + 1, 0);
      #1;
      check("async_reset_state", int'(state), 0);
      check("async_reset_outputs", int'(outv), 0);
    end
    m_st = 0;
    m_retry = 0;
    m_entry = cyc;
    repeat (2) step(0, 0);
    @(posedge sysclk);
    #1;
    reset_INV = 1'b1;
    predict();
  endtask
  initial begin
    int prev = -1;
    exp_t e;
    forever begin
      @(negedge sysclk);
      if (int'(state) != prev) begin
        prev = int'(state);
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_transition: got state %0d at cycle %0d, required no change", state, cyc);
        end else begin
          e = q.pop_front();
          check("state", int'(state), e.st);
          check("outputs", int'(outv), int'(e.o));
          if (e.t >= 0) check("transition_cycle", cyc, e.t);
        end
      end
    end
  end
  initial begin
    bit en, ro;
    push(-1, 0);
    repeat (3) step(0, 0);
    @(posedge sysclk);
    #1;
    reset_INV = 1'b1;
    predict();
    step(0, 0);
    // nominal boot, resetout rising 5 cycles into BOOTWAIT
    wait_st(4, 40, 1, 0);
    repeat (4) step(1, 0);
    wait_st(6, 40, 1, 1);
    repeat (5) step(1, 1);
    // watchdog from RUN, then three timeouts into FAULT
    wait_st(4, 5, 1, 0);
    wait_st(8, 200, 1, 0);
    repeat (6) step(1, 0);
    // recovery; two timeouts then success on the timer-done cycle
    step(0, 0);
    wait_st(4, 40, 1, 0);
    wait_st(7, 40, 1, 0);
    wait_st(4, 40, 1, 0);
    wait_st(7, 40, 1, 0);
    wait_st(4, 40, 1, 0);
    while (cyc + 2 < m_entry + 14) step(1, 0);
    step(1, 1);
    wait_st(6, 40, 1, 1);
    repeat (3) step(1, 1);
    // enable drop mid-SETTLE, then async reset mid-HUBDLY
    step(0, 1);
    wait_st(2, 40, 1, 0);
    repeat (3) step(1, 0);
    repeat (2) step(0, 0);
    wait_st(4, 40, 1, 0);
    wait_st(5, 40, 1, 1);
    repeat (3) step(1, 1);
    hard_reset();
    repeat (2) step(0, 0);
    en = 1'b1;
    ro = 1'b0;
    repeat (2500) begin
      en = $urandom_range(0, 99) != 0;
      if ($urandom_range(0, 9) == 0) ro = !ro;
      if ($urandom_range(0, 599) == 0) hard_reset();
      else step(en, ro);
    end
    repeat (4) step(1, 0);
    repeat (3) @(negedge sysclk);
    #1;
    check("pending_transitions", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
